// File: rtl/ofm_pkg.sv
// Shared types and helpers for the OFM pack writer: widths, FSM encoding and the
// signed 8-bit saturation used by the requantizer.
package ofm_pkg;
    localparam int ACC_W  = 25;
    localparam int BYTE_W = 8;
    localparam int LANES  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic logic [BYTE_W-1:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127) begin
            return 8'h7F;
        end else if (v < -32'sd128) begin
            return 8'h80;
        end else begin
            return v[BYTE_W-1:0];
        end
    endfunction
endpackage

// File: rtl/ofm_word_fifo.sv
// Synchronous word FIFO with first-word fall-through through a registered read port;
// a freshly written word becomes visible one cycle after the write. clr empties it.
module ofm_word_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    output logic         empty,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  rd_data_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d, remain;
    logic          valid_q, valid_d, do_push, do_pop, full;

    // The head slot is never overwritten while occupied, so the read register holds
    // the presented word stable until it is popped.
    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        do_pop   = pop && valid_q;
        do_push  = push && (!full || do_pop);
        drop     = push && !do_push;
        remain   = count_q - (AW+1)'(do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = remain + (AW+1)'(do_push);
        valid_d  = (remain != '0);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr_q] <= push_data;
        end
        rd_data_q <= mem[rd_ptr_d];
    end

    assign dout       = valid_q ? rd_data_q : '0;
    assign dout_valid = valid_q;
    assign empty      = (count_q == '0);
endmodule

// File: rtl/ofm_pack_writer.sv
// Requantizes two psum streams to 8 bit, packs them into 64-bit words and streams the
// words out with addresses. Define OFM_RELU_EN to clamp negative bytes to zero.
module ofm_pack_writer #(
    parameter int ACC_W      = ofm_pkg::ACC_W,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_conv,
    input  logic              end_conv,
    input  logic [4:0]        cfg_shift,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ACC_W-1:0]  ofm_port0,
    input  logic              ofm_port0_v,
    input  logic [ACC_W-1:0]  ofm_port1,
    input  logic              ofm_port1_v,
    output logic [63:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    import ofm_pkg::*;
    localparam int WORD_W = LANES * BYTE_W;

    state_t              state_q, state_d;
    logic                flush_cnt_q, flush_cnt_d;
    logic [4:0]          shift_q, shift_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ovf_q, ovf_d;
    logic [BYTE_W-1:0]   byte_q [2];
    logic [BYTE_W-1:0]   byte_d [2];
    logic [1:0]          bv_q, bv_d;
    logic [WORD_W-1:0]   word_q, word_d, push_word;
    logic [2:0]          cnt_q, cnt_d;
    logic                push, fifo_empty, fifo_drop;

    logic [ACC_W-1:0]    port_x [2];
    logic [1:0]          port_v;
    logic [BYTE_W-1:0]   req_byte [2];

    assign port_x[0] = ofm_port0;
    assign port_x[1] = ofm_port1;
    assign port_v    = {ofm_port1_v, ofm_port0_v};

    // One extra bit of headroom keeps the rounding add from wrapping.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic signed [ACC_W:0]  ext, rnd, shifted;
        logic        [BYTE_W-1:0] sat;
        assign ext     = {port_x[gi][ACC_W-1], port_x[gi]};
        assign rnd     = (shift_q == 5'd0) ? '0 : ((ACC_W+1)'(1) << (shift_q - 5'd1));
        assign shifted = (ext + rnd) >>> shift_q;
        assign sat     = sat8(32'(shifted));
`ifdef OFM_RELU_EN
        assign req_byte[gi] = sat[BYTE_W-1] ? '0 : sat;
`else
        assign req_byte[gi] = sat;
`endif
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            byte_d[i] = req_byte[i];
            bv_d[i]   = (state_q == ST_RUN) && !start_conv && port_v[i];
        end
    end

    // Port0 byte lands before port1 byte; at most one word can complete per cycle.
    always_comb begin
        word_d    = word_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_word = '0;
        for (int i = 0; i < 2; i++) begin
            if (bv_q[i]) begin
                word_d[BYTE_W*cnt_d +: BYTE_W] = byte_q[i];
                if (cnt_d == 3'd7) begin
                    push      = 1'b1;
                    push_word = word_d;
                    word_d    = '0;
                    cnt_d     = 3'd0;
                end else begin
                    cnt_d = cnt_d + 3'd1;
                end
            end
        end
        if (state_q == ST_FLUSH && flush_cnt_q && cnt_q != 3'd0) begin
            push      = 1'b1;
            push_word = word_q;
            word_d    = '0;
            cnt_d     = 3'd0;
        end
        if (start_conv) begin
            push   = 1'b0;
            word_d = '0;
            cnt_d  = 3'd0;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        ovf_d       = ovf_q || fifo_drop;
        done        = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (end_conv) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: ;
        endcase
        if (out_valid && out_ready) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        if (start_conv) begin
            state_d     = ST_RUN;
            flush_cnt_d = 1'b0;
            shift_d     = cfg_shift;
            addr_d      = cfg_base;
            ovf_d       = 1'b0;
            done        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 1'b0;
            shift_q     <= '0;
            addr_q      <= '0;
            ovf_q       <= 1'b0;
            byte_q[0]   <= '0;
            byte_q[1]   <= '0;
            bv_q        <= '0;
            word_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            ovf_q       <= ovf_d;
            byte_q[0]   <= byte_d[0];
            byte_q[1]   <= byte_d[1];
            bv_q        <= bv_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
        end
    end

    ofm_word_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_conv),
        .push       (push),
        .push_data  (push_word),
        .pop        (out_ready),
        .dout       (out_data),
        .dout_valid (out_valid),
        .empty      (fifo_empty),
        .drop       (fifo_drop)
    );

    assign out_addr = addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign overflow = ovf_q;
endmodule

// File: tb/tb_ofm_pack_writer.sv
// Directed and randomized checks of ofm_pack_writer against a byte-stream reference
// model: requantize each accepted psum, chunk the stream into zero-padded 8-byte words.
module tb_ofm_pack_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_conv = 1'b0, end_conv = 1'b0;
    logic [4:0]  cfg_shift = '0;
    logic [9:0]  cfg_base = '0;
    logic [24:0] p0 = '0, p1 = '0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [63:0] out_data;
    logic [9:0]  out_addr;
    logic        out_valid, busy, done, overflow;
    logic        out_ready = 1'b0;

    int checks = 0, failures = 0, done_cnt = 0;
    int cur_shift = 0;
    bit rand_ready = 1'b0;
    logic [63:0] got_data[$];
    logic [9:0]  got_addr[$];
    logic [7:0]  exp_bytes[$];

    typedef struct {bit v0; int x0; bit v1; int x1;} beat_t;
    beat_t stim[$];

    ofm_pack_writer dut (
        .clk(clk), .rst_n(rst_n), .start_conv(start_conv), .end_conv(end_conv),
        .cfg_shift(cfg_shift), .cfg_base(cfg_base),
        .ofm_port0(p0), .ofm_port0_v(v0), .ofm_port1(p1), .ofm_port1_v(v1),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_addr.push_back(out_addr);
            end
            if (done) done_cnt++;
        end
    end

    function automatic logic [7:0] ref_q(int x, int sh);
        longint v;
        v = x;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
`ifdef OFM_RELU_EN
        if (v < 0) v = 0;
`endif
        return v[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_layer(int sh, int base);
        cfg_shift  = 5'(sh);
        cfg_base   = 10'(base);
        start_conv = 1'b1;
        tick();
        start_conv = 1'b0;
        cur_shift  = sh;
        got_data.delete();
        got_addr.delete();
        exp_bytes.delete();
    endtask

    task automatic drive(bit with_end);
        int n = stim.size();
        for (int i = 0; i < n; i++) begin
            beat_t s = stim[i];
            p0 = s.x0[24:0];
            p1 = s.x1[24:0];
            v0 = s.v0;
            v1 = s.v1;
            end_conv = with_end && (i == n - 1);
            if (s.v0) exp_bytes.push_back(ref_q(s.x0, cur_shift));
            if (s.v1) exp_bytes.push_back(ref_q(s.x1, cur_shift));
            tick();
        end
        v0 = 1'b0; v1 = 1'b0; end_conv = 1'b0; p0 = '0; p1 = '0;
        stim.delete();
    endtask

    task automatic wait_done(string tag, int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_words(string tag, int base, int max_words);
        int nb = exp_bytes.size();
        int nw = (nb + 7) / 8;
        int ng;
        if (nw > max_words) nw = max_words;
        chk({tag, "_nwords"}, 64'(got_data.size()), 64'(nw));
        ng = (got_data.size() < nw) ? got_data.size() : nw;
        for (int w = 0; w < ng; w++) begin
            logic [63:0] ew = '0;
            for (int b = 0; b < 8; b++)
                if (w * 8 + b < nb) ew[8*b +: 8] = exp_bytes[w*8 + b];
            chk($sformatf("%s_data%0d", tag, w), got_data[w], ew);
            chk($sformatf("%s_addr%0d", tag, w), 64'(got_addr[w]), 64'((base + w) % 1024));
        end
    endtask

    function automatic int rand_psum();
        logic signed [24:0] t;
        t = $urandom();
        t = t >>> $urandom_range(0, 24);
        return int'(t);
    endfunction

    initial begin
        logic [63:0] ew;
        int d0;

        repeat (3) tick();
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", 64'(out_addr), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_ovf", 64'(overflow), 0);
        rst_n = 1'b1;
        tick();

        // 1: one full word, latency to out_valid
        out_ready = 1'b1;
        start_layer(0, 'h10);
        chk("t1_busy", 64'(busy), 1);
        for (int i = 0; i < 4; i++) stim.push_back('{1'b1, 2*i + 1, 1'b1, 2*i + 2});
        drive(1'b1);
        chk("t1_lat_n0", 64'(out_valid), 0);
        tick();
        chk("t1_lat_n1", 64'(out_valid), 0);
        tick();
        chk("t1_lat_n2", 64'(out_valid), 1);
        chk("t1_word", out_data, 64'h0807060504030201);
        chk("t1_addr", 64'(out_addr), 64'h10);
        wait_done("t1", 50);
        check_words("t1", 'h10, 99);

        // 2: rounding shift
        start_layer(4, 'h20);
        stim.push_back('{1'b1, 248, 1'b0, 0});
        stim.push_back('{1'b1, -100, 1'b0, 0});
        drive(1'b1);
        wait_done("t2", 50);
`ifdef OFM_RELU_EN
        ew = 64'h0010;
`else
        ew = 64'hFA10;
`endif
        chk("t2_word", (got_data.size() > 0) ? got_data[0] : 64'hX, ew);
        check_words("t2", 'h20, 99);

        // 3: saturation
        start_layer(0, 'h30);
        stim.push_back('{1'b1, 1000, 1'b1, -1000});
        drive(1'b1);
        wait_done("t3a", 50);
`ifdef OFM_RELU_EN
        ew = 64'h007F;
`else
        ew = 64'h807F;
`endif
        chk("t3_sat", (got_data.size() > 0) ? got_data[0] : 64'hX, ew);
        start_layer(24, 'h40);
        stim.push_back('{1'b1, -(1 << 24), 1'b0, 0});
        drive(1'b1);
        wait_done("t3b", 50);
`ifdef OFM_RELU_EN
        ew = 64'h00;
`else
        ew = 64'hFF;
`endif
        chk("t3_maxneg", (got_data.size() > 0) ? got_data[0] : 64'hX, ew);
        chk("t3_nwords", 64'(got_data.size()), 1);

        // 4: odd split across a word boundary
        start_layer(0, 'h50);
        for (int i = 0; i < 7; i++) stim.push_back('{1'b0, 0, 1'b1, 10 + i});
        stim.push_back('{1'b1, 20, 1'b1, 21});
        drive(1'b1);
        wait_done("t4", 50);
        chk("t4_w0", (got_data.size() > 0) ? got_data[0] : 64'hX, 64'h14100F0E0D0C0B0A);
        chk("t4_w1", (got_data.size() > 1) ? got_data[1] : 64'hX, 64'h15);
        check_words("t4", 'h50, 99);

        // 5: stalled sink, FIFO overflow
        out_ready = 1'b0;
        start_layer(0, 'h60);
        for (int i = 0; i < 40; i++) stim.push_back('{1'b1, rand_psum(), 1'b1, rand_psum()});
        drive(1'b1);
        repeat (3) tick();
        chk("t5_ovf", 64'(overflow), 1);
        chk("t5_valid", 64'(out_valid), 1);
        out_ready = 1'b1;
        wait_done("t5", 60);
        check_words("t5", 'h60, 8);
        chk("t5_ovf_sticky", 64'(overflow), 1);

        // 6: restart during drain
        out_ready = 1'b0;
        start_layer(0, 'h70);
        chk("t6_ovf_clr", 64'(overflow), 0);
        for (int i = 0; i < 12; i++) stim.push_back('{1'b1, i, 1'b1, i + 100});
        drive(1'b1);
        repeat (4) tick();
        chk("t6_queued", 64'(out_valid), 1);
        d0 = done_cnt;
        start_layer(3, 'h155);
        chk("t6_valid0", 64'(out_valid), 0);
        chk("t6_addr", 64'(out_addr), 64'h155);
        chk("t6_busy", 64'(busy), 1);
        out_ready = 1'b1;
        repeat (5) tick();
        chk("t6_nodone", 64'(done_cnt - d0), 0);
        chk("t6_noword", 64'(got_data.size()), 0);
        for (int i = 0; i < 10; i++) stim.push_back('{1'b1, rand_psum(), 1'b1, rand_psum()});
        drive(1'b1);
        wait_done("t6", 60);
        check_words("t6", 'h155, 99);

        // randomized layers, including address wrap and a throttled sink
        for (int l = 0; l < 6; l++) begin
            int sh = $urandom_range(0, 24);
            int base = (l == 2) ? 1020 : $urandom_range(0, 1023);
            int nc = $urandom_range(20, 60);
            rand_ready = l[0];
            start_layer(sh, base);
            for (int i = 0; i < nc; i++)
                stim.push_back('{($urandom_range(0, 3) != 0), rand_psum(),
                                 ($urandom_range(0, 3) != 0), rand_psum()});
            drive(1'b1);
            wait_done($sformatf("rnd%0d", l), 400);
            check_words($sformatf("rnd%0d", l), base, 99);
            chk($sformatf("rnd%0d_ovf", l), 64'(overflow), 0);
        end
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
